// File: rtl/oled_pkg.sv
// Shared OLED geometry, coordinate types, mover FSM states and the per-axis step helper.
// SPRITE_POS_CTRL_WRAP_EN selects wrap-around instead of saturation at the screen edges.
package oled_pkg;

  localparam int unsigned SCREEN_W  = 96;
  localparam int unsigned SCREEN_H  = 64;
  localparam int unsigned COORD_W   = 7;
  localparam int unsigned PIX_IDX_W = 13;

  typedef logic [COORD_W-1:0]   coord_t;
  typedef logic [PIX_IDX_W-1:0] pix_idx_t;

  typedef enum logic [1:0] {
    MV_IDLE   = 2'd0,
    MV_DELAY  = 2'd1,
    MV_REPEAT = 2'd2
  } mv_state_t;

  // Move one axis by d (-1/0/+1) within [0, lim]; math in 8-bit signed, truncated after the bound check.
  function automatic coord_t step_axis(coord_t pos, logic signed [7:0] d, coord_t lim);
    logic signed [7:0] sum;
    logic signed [7:0] lim_s;
    sum   = $signed({1'b0, pos}) + d;
    lim_s = $signed({1'b0, lim});
`ifdef SPRITE_POS_CTRL_WRAP_EN
    if (sum < 8'sd0)      sum = lim_s;
    else if (sum > lim_s) sum = 8'sd0;
`else
    if (sum < 8'sd0)      sum = 8'sd0;
    else if (sum > lim_s) sum = lim_s;
`endif
    return COORD_W'(sum);
  endfunction

endpackage

// File: rtl/sprite_pos_ctrl_if.sv
// Button inputs and sprite position outputs of the sprite position controller.
interface sprite_pos_ctrl_if;
  import oled_pkg::*;

  logic   btn_u;
  logic   btn_d;
  logic   btn_l;
  logic   btn_r;
  logic   btn_c;
  coord_t x;
  coord_t y;
  logic   moving;

  modport master (output btn_u, btn_d, btn_l, btn_r, btn_c, input x, y, moving);
  modport slave  (input btn_u, btn_d, btn_l, btn_r, btn_c, output x, y, moving);
endinterface

// File: rtl/btn_debounce.sv
// Two-flop synchronizer plus debouncer: the output follows the synchronized level
// only after it has differed from the output for DEB_CYCLES consecutive cycles.
module btn_debounce #(
  parameter int unsigned DEB_CYCLES = 62500
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic btn_db
);

  localparam int unsigned CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      btn_db <= 1'b0;
      cnt    <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      if (sync2 == btn_db) begin
        cnt <= '0;
      end else if (cnt == CW'(DEB_CYCLES - 1)) begin
        btn_db <= sync2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/sprite_pos_ctrl.sv
// Debounced five-button sprite mover: single step per press, auto-repeat while held,
// position bounded to keep the sprite on screen (wraps when SPRITE_POS_CTRL_WRAP_EN is defined).
module sprite_pos_ctrl
  import oled_pkg::*;
#(
  parameter int unsigned SPRITE_W     = 18,
  parameter int unsigned SPRITE_H     = 9,
  parameter int unsigned HOME_X       = 0,
  parameter int unsigned HOME_Y       = 0,
  parameter int unsigned DEB_CYCLES   = 62500,
  parameter int unsigned TICK_CYCLES  = 62500,
  parameter int unsigned REPEAT_TICKS = 30
) (
  input  logic              clk,
  input  logic              rst_n,
  sprite_pos_ctrl_if.slave  bus
);

  localparam int unsigned TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int unsigned RW = (REPEAT_TICKS > 1) ? $clog2(REPEAT_TICKS) : 1;
  localparam coord_t X_MAX  = COORD_W'(SCREEN_W - SPRITE_W);
  localparam coord_t Y_MAX  = COORD_W'(SCREEN_H - SPRITE_H);

  // Bit order: u, d, l, r, c
  logic [4:0] raw;
  logic [4:0] db;

  assign raw = {bus.btn_c, bus.btn_r, bus.btn_l, bus.btn_d, bus.btn_u};

  for (genvar i = 0; i < 5; i++) begin : g_deb
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk     (clk),
      .rst_n   (rst_n),
      .btn_raw (raw[i]),
      .btn_db  (db[i])
    );
  end

  mv_state_t         state, state_nxt;
  coord_t            x_q, x_nxt, y_q, y_nxt;
  logic [TW-1:0]     tcnt, tcnt_nxt;
  logic [RW-1:0]     rcnt, rcnt_nxt;
  logic              moving_q, moving_nxt;
  logic              act_q, c_q;
  logic signed [7:0] dx, dy;
  logic              active, tick, c_rise;

  assign dx     = $signed(8'(db[3])) - $signed(8'(db[2]));
  assign dy     = $signed(8'(db[1])) - $signed(8'(db[0]));
  assign active = (dx != 8'sd0) || (dy != 8'sd0);
  assign tick   = (tcnt == TW'(TICK_CYCLES - 1));
  assign c_rise = db[4] && !c_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= MV_IDLE;
      x_q      <= COORD_W'(HOME_X);
      y_q      <= COORD_W'(HOME_Y);
      tcnt     <= '0;
      rcnt     <= '0;
      moving_q <= 1'b0;
      act_q    <= 1'b0;
      c_q      <= 1'b0;
    end else begin
      state    <= state_nxt;
      x_q      <= x_nxt;
      y_q      <= y_nxt;
      tcnt     <= tcnt_nxt;
      rcnt     <= rcnt_nxt;
      moving_q <= moving_nxt;
      act_q    <= active;
      c_q      <= db[4];
    end
  end

  // Centre recall overrides any step; a step from IDLE needs a fresh inactive->active edge.
  always_comb begin
    state_nxt = state;
    x_nxt     = x_q;
    y_nxt     = y_q;
    tcnt_nxt  = tick ? '0 : tcnt + TW'(1);
    rcnt_nxt  = rcnt;
    if (c_rise) begin
      x_nxt     = COORD_W'(HOME_X);
      y_nxt     = COORD_W'(HOME_Y);
      state_nxt = MV_IDLE;
    end else begin
      case (state)
        MV_IDLE: begin
          if (active && !act_q) begin
            x_nxt     = step_axis(x_q, dx, X_MAX);
            y_nxt     = step_axis(y_q, dy, Y_MAX);
            tcnt_nxt  = '0;
            rcnt_nxt  = '0;
            state_nxt = MV_DELAY;
          end
        end
        MV_DELAY: begin
          if (!active) begin
            state_nxt = MV_IDLE;
          end else if (tick) begin
            if (rcnt == RW'(REPEAT_TICKS - 1)) state_nxt = MV_REPEAT;
            else                               rcnt_nxt  = rcnt + RW'(1);
          end
        end
        MV_REPEAT: begin
          if (!active) begin
            state_nxt = MV_IDLE;
          end else if (tick) begin
            x_nxt = step_axis(x_q, dx, X_MAX);
            y_nxt = step_axis(y_q, dy, Y_MAX);
          end
        end
        default: state_nxt = MV_IDLE;
      endcase
    end
    moving_nxt = (state_nxt == MV_REPEAT);
  end

  assign bus.x      = x_q;
  assign bus.y      = y_q;
  assign bus.moving = moving_q;

endmodule
